// File: rtl/vec3_length_arbiter_pkg.sv
// vec3_length_arbiter_pkg: shared vec3 type and tag sizing for the length arbiter
package vec3_length_arbiter_pkg;
  localparam int VEC_W = 32;
  localparam int MAX_NREQ = 8;
  function automatic int tag_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int TAG_W = tag_w(MAX_NREQ);
  typedef struct packed {
    logic [VEC_W-1:0] x;
    logic [VEC_W-1:0] y;
    logic [VEC_W-1:0] z;
  } vec3;
endpackage

// File: rtl/vec3_length_arbiter_tag_fifo.sv
// tag_fifo: in-order requester tag queue; an empty FIFO forwards din straight to dout
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic [TW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [TW-1:0] mem_q [DEPTH];
  logic [TW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? din : mem_q[rd_q];
  // push and pop on an empty FIFO is a pure bypass: nothing is stored
  assign wr_en = push && !(pop && empty);
  assign rd_en = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(wr_en);
    rd_d = rd_q + AW'(rd_en);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/vec3_length_arbiter.sv
// vec3_length_arbiter: round-robin sharing of one vec3 length unit among NREQ requesters,
// routing in-order results back to their owners with one registered cycle of latency.
module vec3_length_arbiter
  import vec3_length_arbiter_pkg::*;
#(
  parameter int N = 32,
  parameter int FRAC = 24,
  parameter int NREQ = 4,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  vec3  [NREQ-1:0] req_vec,
  output logic [NREQ-1:0] req_ready,
  output vec3             len_vec,
  output logic            len_valid_in,
  input  logic [N-1:0]    len_length,
  input  logic            len_valid_out,
  output logic [NREQ-1:0] resp_valid,
  output logic [N-1:0]    resp_length,
  output logic            busy,
  output logic            err
);
  localparam int GW = tag_w(NREQ);
  if (FRAC > N || NREQ < 2 || NREQ > (1 << TAG_W) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("vec3_length_arbiter: illegal parameters");
  end
  logic [GW-1:0] ptr_q, ptr_d, gnt, head;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [N-1:0] resp_length_q, resp_length_d;
  logic err_q, err_d;
  logic any, push, pop, full, empty;
  int idx;
  always_comb begin
    gnt = ptr_q;
    any = 1'b0;
    idx = 0;
    // scan from farthest to nearest so the nearest valid requester wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt = GW'(idx);
        any = 1'b1;
      end
    end
    push = rst && any && (!full || len_valid_out);
    pop = rst && len_valid_out && (!empty || push);
    req_ready = push ? NREQ'(1) << gnt : '0;
    ptr_d = push ? (gnt == GW'(NREQ - 1) ? '0 : gnt + 1'b1) : ptr_q;
    resp_valid_d = pop ? NREQ'(1) << head : '0;
    resp_length_d = pop ? len_length : resp_length_q;
    err_d = err_q || (rst && len_valid_out && empty && !push);
  end
  tag_fifo #(.DEPTH(DEPTH), .TW(GW)) u_tag_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(gnt),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      resp_valid_q <= '0;
      resp_length_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_length_q <= resp_length_d;
      err_q <= err_d;
    end
  end
  assign len_vec = req_vec[gnt];
  assign len_valid_in = push;
  assign resp_valid = resp_valid_q;
  assign resp_length = resp_length_q;
  assign busy = !empty;
  assign err = err_q;
endmodule

// File: tb/tb_vec3_length_arbiter.sv
// tb_vec3_length_arbiter: random and directed stimulus against a queue-based reference model
module tb_vec3_length_arbiter;
  import vec3_length_arbiter_pkg::*;
  localparam int NREQ = 4;
  localparam int DEPTH = 8;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  vec3 [NREQ-1:0] req_vec = '0;
  logic [NREQ-1:0] req_ready, resp_valid;
  vec3 len_vec;
  logic len_valid_in, len_valid_out, busy, err;
  logic [N-1:0] len_length, resp_length;
  always #5 clk = ~clk;
  vec3_length_arbiter #(.N(N), .FRAC(24), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_vec(req_vec), .req_ready(req_ready),
    .len_vec(len_vec), .len_valid_in(len_valid_in), .len_length(len_length),
    .len_valid_out(len_valid_out), .resp_valid(resp_valid), .resp_length(resp_length),
    .busy(busy), .err(err)
  );
  int checks = 0;
  int passes = 0;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [31:0] ref_len(vec3 v);
    real x, y, z, r;
    longint l;
    x = real'(v.x) / 16777216.0;
    y = real'(v.y) / 16777216.0;
    z = real'(v.z) / 16777216.0;
    r = $sqrt(x * x + y * y + z * z) * 16777216.0;
    l = longint'(r);
    return l[31:0];
  endfunction
  function automatic vec3 mk(int a, int b, int c);
    vec3 v;
    v.x = 32'(a) << 24;
    v.y = 32'(b) << 24;
    v.z = 32'(c) << 24;
    return v;
  endfunction
  // emulated length unit: lat 0 is combinational, otherwise an in-order ring with stall
  int lat = 1;
  int cyc = 0;
  logic stall = 1'b0;
  logic spur = 1'b0;
  logic [31:0] rlen [256];
  int rdue [256];
  int rh = 0;
  int rt = 0;
  always_comb begin
    len_valid_out = spur;
    len_length = 32'hDEAD_BEEF;
    if (lat == 0) begin
      if (len_valid_in) begin
        len_valid_out = 1'b1;
        len_length = ref_len(len_vec);
      end
    end else if (!stall && rh != rt && rdue[rh % 256] <= cyc) begin
      len_valid_out = 1'b1;
      len_length = rlen[rh % 256];
    end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      rh <= 0;
      rt <= 0;
    end else begin
      if (lat > 0 && len_valid_in) begin
        rlen[rt % 256] <= ref_len(len_vec);
        rdue[rt % 256] <= cyc + lat;
        rt <= rt + 1;
      end
      if (lat > 0 && len_valid_out && !spur) rh <= rh + 1;
    end
  end
  int mq[$];
  int mptr = 0;
  logic [NREQ-1:0] m_rv = '0;
  logic [31:0] m_rl = '0;
  logic m_err = 1'b0;
  bit chk_en = 1'b0;
  always @(negedge clk) if (chk_en) begin
    automatic int g = -1;
    automatic bit issue;
    for (int k = 0; k < NREQ; k++) if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
    issue = rst && g >= 0 && (mq.size() < DEPTH || len_valid_out);
    chk("busy", busy, mq.size() != 0);
    chk("err", err, m_err);
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_length", resp_length, m_rl);
    chk("len_valid_in", len_valid_in, issue);
    chk("req_ready", req_ready, issue ? (1 << g) : 0);
    if (issue) chk("len_vec", len_vec, req_vec[g]);
    if (!rst) begin
      mq.delete();
      mptr = 0;
      m_rv = '0;
      m_rl = '0;
      m_err = 1'b0;
    end else begin
      if (issue) begin
        mq.push_back(g);
        mptr = (g + 1) % NREQ;
      end
      m_rv = '0;
      if (len_valid_out) begin
        if (mq.size() > 0) begin
          automatic int t = mq.pop_front();
          m_rv = NREQ'(1) << t;
          m_rl = len_length;
        end else m_err = 1'b1;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask
  initial begin
    int k, n, sp;
    step();
    chk_en = 1'b1;
    // single request, latency 3
    lat = 3;
    do_reset();
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    step();
    req_vec[2] = mk(3, 4, 0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (resp_valid == 0 && k < 10);
    chk("single latency", k, 4);
    chk("single resp_valid", resp_valid, 4'b0100);
    chk("single resp_length", resp_length, 32'h0500_0000);
    // contention, latency 2
    req_vec = {mk(1, 4, 8), mk(2, 3, 6), mk(3, 4, 0), mk(1, 2, 2)};
    req_valid = 4'hF;
    lat = 2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("contention grant%0d", i), req_ready, 4'b1 << (i % 4));
      if (i == 3) chk("contention resp0 len", {resp_valid, resp_length}, {4'b0001, 32'h0300_0000});
      if (i == 4) chk("contention resp1 len", {resp_valid, resp_length}, {4'b0010, 32'h0500_0000});
      if (i == 6) chk("contention resp3 len", {resp_valid, resp_length}, {4'b1000, 32'h0900_0000});
    end
    step();
    req_valid = '0;
    repeat (8) step();
    // FIFO full with stalled unit
    lat = 1;
    stall = 1'b1;
    req_valid = 4'hF;
    do_reset();
    n = 0;
    repeat (12) begin
      @(negedge clk);
      n += int'(len_valid_in);
    end
    chk("full issues", n, 8);
    chk("full stalled", len_valid_in, 0);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("full refill", len_valid_in, 1);
    step();
    stall = 1'b1;
    @(negedge clk);
    chk("full one more", len_valid_in, 0);
    chk("full resp", resp_valid, 4'b0001);
    step();
    req_valid = '0;
    stall = 1'b0;
    repeat (12) step();
    // zero-latency unit
    lat = 0;
    do_reset();
    req_vec[1] = mk(20, 18, 3);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("zero ready", req_ready, 4'b0010);
    chk("zero busy", busy, 0);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("zero resp_valid", resp_valid, 4'b0010);
    chk("zero resp int", resp_length[31:24], 8'd27);
    chk("zero busy after", busy, 0);
    // spurious result
    lat = 1;
    do_reset();
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    @(negedge clk);
    chk("spur err", err, 1);
    chk("spur resp", resp_valid, 0);
    repeat (3) step();
    @(negedge clk);
    chk("spur sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("spur cleared", err, 0);
    // reset mid-flight
    lat = 6;
    req_vec = {mk(1, 4, 8), mk(2, 3, 6), mk(3, 4, 0), mk(1, 2, 2)};
    step();
    req_valid = 4'b0111;
    repeat (3) step();
    req_valid = '0;
    @(negedge clk);
    chk("midflight busy", busy, 1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midflight busy cleared", busy, 0);
    chk("midflight resp", resp_valid, 0);
    step();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("midflight regrant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    repeat (10) step();
    // randomized batches
    for (int b = 0; b < 8; b++) begin
      lat = (b == 0) ? 0 : $urandom_range(0, 4);
      sp = (b % 2 == 1) ? 80 : 10;
      do_reset();
      repeat (250) begin
        req_valid = NREQ'($urandom_range(0, 15));
        for (int i = 0; i < NREQ; i++) req_vec[i] = '{$urandom >> 1, $urandom >> 1, $urandom >> 1};
        stall = (lat > 0) && ($urandom_range(0, 99) < sp);
        step();
      end
      req_valid = '0;
      stall = 1'b0;
      repeat (20) step();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
